mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, downstream of the register file.
//  Consumes the two register-file operands and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Holds the architectural HI/LO registers.
//  Provides HI/LO to MFHI/MFLO and a stall request while a result is pending.
// PARAMETERS
//  WIDTH   32  operand / HI / LO width; the iteration count equals WIDTH.
// PORTS
//  Clk       in   1      clock; all state updates on posedge.
//  Rst_n     in   1      async active-low reset; asserting it clears state immediately.
//  Start     in   1      request; accepted only in a cycle where Busy==0.
//  Op        in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; others ignored.
//  OperandA  in   WIDTH  rs value (ReadData1): multiplicand, dividend, or MTHI/MTLO source.
//  OperandB  in   WIDTH  rt value (ReadData2): multiplier or divisor.
//  HiLoRead  in   1      the instruction in EX is MFHI or MFLO.
//  Busy      out  1      an operation is in progress.
//  Done      out  1      one-cycle pulse; HI/LO have just been updated by MULT*/DIV*.
//  Stall     out  1      Busy & (HiLoRead | Start); combinational.
//  Hi        out  WIDTH  architectural HI register.
//  Lo        out  WIDTH  architectural LO register.
// BEHAVIOUR
//  Reset: state IDLE; Hi, Lo, Busy, Done and all internal registers are 0.
//  FSM: IDLE -> CALC -> FIX -> IDLE.
//  - IDLE: on Start with a MULT*/DIV* op, latch operands and go to CALC.
//    For signed ops, operand magnitudes are latched along with the sign bits.
//  - IDLE: on Start with MTHI or MTLO, write OperandA into Hi or Lo at that edge.
//    No Busy, no Done; state stays IDLE.
//  - CALC: exactly WIDTH cycles.
//    Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
//    Divide: restoring, one quotient bit per cycle, MSB first; remainder register is WIDTH+1 bits.
//  - FIX: one cycle. Applies signs, writes Hi/Lo, sets Done for the next cycle, returns to IDLE.
//    MULT: if signA^signB, the 2*WIDTH product is negated.
//    DIV: quotient is negated if signA^signB; remainder takes the sign of the dividend.
//  Result placement:
//    Multiply: Hi = product[2W-1:W], Lo = product[W-1:0].
//    Divide:   Lo = quotient, Hi = remainder.
//  Latency: Start sampled at edge 0 -> Hi/Lo updated at edge WIDTH+1 (33).
//    Busy is high from after edge 0 until edge 33; Done is high for the cycle after edge 33.
//  Hi and Lo keep their old values throughout CALC. They change only at FIX or on MTHI/MTLO.
//  Start while Busy: ignored. Stall stays high so upstream holds the instruction.
//    The request is accepted in the first cycle with Busy==0.
//  Divide by zero (DIV or DIVU): Lo = all ones, Hi = OperandA unchanged. No sign fix.
//  DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0 (two's-complement wrap). No trap.
//  Reserved Op values with Start: no effect.
//  Rst_n asserted mid-operation: the operation is abandoned.
//    Hi/Lo return to 0, and no Done is issued after release.
//  Stall is never asserted in IDLE, so there is no deadlock on back-to-back ops.
// STRUCTURE
//  Package mdu_pkg:
//    - Op encodings (MDU_MULT..MDU_MTLO) as localparams.
//    - FSM state encoding (IDLE/CALC/FIX).
//    - Counter width = $clog2(WIDTH)+1.
//  Sub-module mdu_iter_core: accumulator/remainder shift datapath.
//    Inputs: step, op, magnitudes. Outputs: raw product, quotient, remainder.
//  Top level keeps the FSM, counter, sign handling, Hi/Lo and Stall logic.
// TESTING
//  1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> Done after 33 cycles; Hi=0xFFFFFFFE, Lo=0x00000001.
//  2. MULT -7 * 3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
//     Busy is high for exactly 33 cycles and Done pulses once.
//  3. DIV -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
//     DIVU 100 / 7 -> Lo=14, Hi=2.
//  4. DIV 0x12345678 / 0 -> Lo=0xFFFFFFFF, Hi=0x12345678.
//     DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
//  5. Start MULT, then HiLoRead=1 and Start(MTLO) during CALC.
//     Stall stays high until Done, MTLO is deferred, and Lo holds its old value through CALC.
//  6. Drop Rst_n at CALC cycle 10 -> Busy, Hi and Lo become 0 immediately.
//     No Done follows; a fresh MTHI 0xA5A5A5A5 then gives Hi=0xA5A5A5A5 after one edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Wide enough to hold the iteration count itself.
    function automatic int mdu_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shift datapath: LSB-first shift-add multiply and MSB-first restoring divide,
// operating on unsigned magnitudes; one bit per step.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     mag_a_i,
    input  logic [WIDTH-1:0]     mag_b_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [WIDTH-1:0]     quotient_o,
    output logic [WIDTH-1:0]     remainder_o
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   trial;

    // Multiply keeps the multiplier in the low half of acc; divide shifts the
    // dividend out of the low half while quotient bits shift in behind it.
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        opb_d = opb_q;
        div_d = div_q;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        trial = {rem_q, acc_q[WIDTH-1]} - {2'b00, opb_q};
        if (load_i) begin
            div_d = div_i;
            acc_d = {{WIDTH{1'b0}}, (div_i ? mag_a_i : mag_b_i)};
            opb_d = div_i ? mag_b_i : mag_a_i;
            rem_d = '0;
        end else if (step_i) begin
            if (div_q) begin
                rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]} : trial[WIDTH:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~trial[WIDTH+1]};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc_q <= '0;
            rem_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            opb_q <= opb_d;
            div_q <= div_d;
        end
    end

    assign product_o   = acc_q;
    assign quotient_o  = acc_q[WIDTH-1:0];
    assign remainder_o = rem_q[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: sequencing FSM, iteration counter, sign fix-up,
// architectural HI/LO and the EX-stage stall request.
//   state   | meaning
//   IDLE    | accepts Start; MTHI/MTLO complete here
//   CALC    | WIDTH iteration steps
//   FIX     | sign correction, HI/LO write, Done next cycle
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiLoRead,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = mdu_cnt_w(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic               signed_q, signed_d, div_q, div_d, dzero_q, dzero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   opa_q, opa_d, hi_q, hi_d, lo_q, lo_d;

    logic               is_md, is_div, is_signed, load, step, neg_res;
    logic [WIDTH-1:0]   mag_a, mag_b, quotient, remainder, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] product, prod_fix;

    assign is_md     = (Op <= MDU_DIVU);
    assign is_div    = (Op == MDU_DIV) || (Op == MDU_DIVU);
    assign is_signed = (Op == MDU_MULT) || (Op == MDU_DIV);
    assign mag_a     = (is_signed && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    assign mag_b     = (is_signed && OperandB[WIDTH-1]) ? -OperandB : OperandB;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .load_i      (load),
        .step_i      (step),
        .div_i       (is_div),
        .mag_a_i     (mag_a),
        .mag_b_i     (mag_b),
        .product_o   (product),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    // Remainder follows the dividend's sign; quotient/product the XOR of signs.
    assign neg_res  = signed_q & (sign_a_q ^ sign_b_q);
    assign prod_fix = neg_res ? -product : product;
    assign quo_fix  = neg_res ? -quotient : quotient;
    assign rem_fix  = (signed_q & sign_a_q) ? -remainder : remainder;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        signed_d = signed_q;
        div_d    = div_q;
        dzero_d  = dzero_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_md) begin
                        load     = 1'b1;
                        state_d  = ST_CALC;
                        cnt_d    = CW'(WIDTH - 1);
                        sign_a_d = is_signed & OperandA[WIDTH-1];
                        sign_b_d = is_signed & OperandB[WIDTH-1];
                        signed_d = is_signed;
                        div_d    = is_div;
                        dzero_d  = is_div && (OperandB == '0);
                        opa_d    = OperandA;
                    end else if (Op == MDU_MTHI) begin
                        hi_d = OperandA;
                    end else if (Op == MDU_MTLO) begin
                        lo_d = OperandA;
                    end
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (cnt_q == '0) state_d = ST_FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dzero_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
            dzero_q  <= 1'b0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            signed_q <= signed_d;
            div_q    <= div_d;
            dzero_q  <= dzero_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy  = (state_q != ST_IDLE);
    assign Done  = done_q;
    assign Stall = Busy & (HiLoRead | Start);
    assign Hi    = hi_q;
    assign Lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n, Start, HiLoRead;
    logic [2:0]  Op;
    logic [31:0] OperandA, OperandB;
    logic        Busy, Done, Stall;
    logic [31:0] Hi, Lo;

    int          total = 0;
    int          bad = 0;
    int          busy_left = 0;
    bit          done_pend = 1'b0;
    logic [31:0] mhi = '0, mlo = '0;
    logic [63:0] sb_q[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .HiLoRead(HiLoRead),
        .Busy(Busy), .Done(Done), .Stall(Stall), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (op)
            MDU_MULT:  begin q = sa * sbv; return q; end
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: Busy/Done/Stall timing from the bench's own latency model,
    // results popped from the scoreboard on the expected Done cycle.
    always @(negedge Clk) begin
        logic        exp_busy;
        logic [63:0] e;
        if (Rst_n) begin
            exp_busy = (busy_left > 0);
            chk("busy", Busy, exp_busy);
            chk("done", Done, done_pend);
            chk("stall", Stall, exp_busy && (HiLoRead || Start));
            if (done_pend) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_underflow: got=result want=none (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("result_hi", Hi, e[63:32]);
                    chk("result_lo", Lo, e[31:0]);
                    mhi = e[63:32];
                    mlo = e[31:0];
                end
            end else begin
                chk("hold_hi", Hi, mhi);
                chk("hold_lo", Lo, mlo);
            end
            done_pend = (busy_left == 1);
            if (busy_left > 0) busy_left--;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: got=busy want=idle (t=%0t)", $time);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hlr, input bit use_k, input logic [31:0] khi, input logic [31:0] klo);
        wait_idle();
        #1;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b; HiLoRead = hlr;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        if (op <= MDU_DIVU) begin
            sb_q.push_back(use_k ? {khi, klo} : ref_md(op, a, b));
            busy_left = 33;
        end else if (op == MDU_MTHI) begin
            chk("mthi", Hi, a);
            mhi = a;
        end else if (op == MDU_MTLO) begin
            chk("mtlo", Lo, a);
            mlo = a;
        end else begin
            chk("reserved_busy", Busy, 1'b0);
        end
    endtask

    initial begin
        int n;
        Rst_n = 1'b0; Start = 1'b0; HiLoRead = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
        #3;
        chk("reset_hi", Hi, 32'h0);
        chk("reset_lo", Lo, 32'h0);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_done", Done, 1'b0);
        repeat (3) @(negedge Clk);
        #2 Rst_n = 1'b1;

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(MDU_MULT,  32'hFFFF_FFF9, 32'h3,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'h2,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(MDU_DIVU,  32'd100,       32'd7,         0, 1, 32'd2,         32'd14);
        issue(MDU_DIV,   32'h1234_5678, 32'h0,         0, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0,         32'h8000_0000);
        issue(3'd7,      32'h1,         32'h2,         0, 0, 32'h0,         32'h0);

        // MTLO held against a busy unit must wait for the first idle cycle.
        issue(MDU_MTLO, 32'h0BAD_F00D, 32'h0, 0, 0, 32'h0, 32'h0);
        issue(MDU_MULT, 32'h1234, 32'h10, 0, 0, 32'h0, 32'h0);
        Start = 1'b1; HiLoRead = 1'b1; Op = MDU_MTLO; OperandA = 32'hCAFE_BABE;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Busy && n < 100);
        @(posedge Clk);
        #1;
        Start = 1'b0; HiLoRead = 1'b0;
        chk("mtlo_deferred", Lo, 32'hCAFE_BABE);
        mlo = 32'hCAFE_BABE;

        // Reset in the middle of CALC abandons the operation.
        issue(MDU_MTHI, 32'h1111_1111, 32'h0, 0, 0, 32'h0, 32'h0);
        issue(MDU_MTLO, 32'h2222_2222, 32'h0, 0, 0, 32'h0, 32'h0);
        issue(MDU_MULT, 32'd5, 32'd6, 0, 0, 32'h0, 32'h0);
        repeat (10) @(negedge Clk);
        #2 Rst_n = 1'b0;
        busy_left = 0; done_pend = 1'b0; sb_q.delete();
        #1;
        chk("midop_rst_busy", Busy, 1'b0);
        chk("midop_rst_hi", Hi, 32'h0);
        chk("midop_rst_lo", Lo, 32'h0);
        mhi = '0; mlo = '0;
        repeat (2) @(negedge Clk);
        #2 Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        issue(MDU_MTHI, 32'hA5A5_A5A5, 32'h0, 0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), 0, 32'h0, 32'h0);
        end
        HiLoRead = 1'b0;

        wait_idle();
        repeat (3) @(negedge Clk);
        chk("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
